// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart transmit arbiter: FSM encoding and a width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bits needed to index n items; never less than 1 so single-bit fields stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/uart-side bundle of the transmit arbiter. o_timeout exists only with UART_ARB_WDT_EN.
interface uart_tx_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int WIDTH_DATA = 8
);
  import uart_tx_arbiter_pkg::*;

  localparam int OWNER_W = clog2(N_REQ);

  logic [N_REQ-1:0]            i_req;
  logic [N_REQ-1:0]            i_last;
  logic [N_REQ*WIDTH_DATA-1:0] i_data;
  logic [N_REQ-1:0]            o_ack;
  logic                        o_we;
  logic [WIDTH_DATA-1:0]       o_data;
  logic                        i_mty;
  logic                        o_busy;
  logic [OWNER_W-1:0]          o_owner;
`ifdef UART_ARB_WDT_EN
  logic                        o_timeout;
`endif

  modport slave (
    input  i_req, i_last, i_data, i_mty,
`ifdef UART_ARB_WDT_EN
    output o_timeout,
`endif
    output o_ack, o_we, o_data, o_busy, o_owner
  );

  modport master (
    output i_req, i_last, i_data, i_mty,
`ifdef UART_ARB_WDT_EN
    input  o_timeout,
`endif
    input  o_ack, o_we, o_data, o_busy, o_owner
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, in cyclic order.
module uart_tx_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  assign any_req = |req;

  // Scan from the farthest offset down so the nearest pending requester overwrites last.
  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) winner = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart transmit path between N_REQ requesters.
// Optional lock watchdog and o_timeout output are enabled by defining UART_ARB_WDT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WIDTH_DATA = 8,
  parameter int TIMEOUT    = 1024
) (
  input logic             clk,
  input logic             nrst,
  uart_tx_arbiter_if.slave bus
);
  import uart_tx_arbiter_pkg::*;

  localparam int OWNER_W = clog2(N_REQ);

  state_t                 state_q, state_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d, owner_q, owner_d, winner, ptr_after;
  logic                   busy_q, busy_d, we_q, we_d, last_q, last_d, any_req;
  logic [WIDTH_DATA-1:0]  data_q, data_d, owner_byte;
  logic [N_REQ-1:0]       ack_q, ack_d;

`ifdef UART_ARB_WDT_EN
  localparam int WDT_W = clog2(TIMEOUT);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT - 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;
`endif

  uart_tx_arbiter_rr_picker #(.N_REQ(N_REQ), .PTR_W(OWNER_W)) u_picker (
    .req     (bus.i_req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_byte = bus.i_data[int'(owner_q)*WIDTH_DATA +: WIDTH_DATA];
  // The releasing owner drops to the back of the round-robin order.
  assign ptr_after  = (owner_q == OWNER_W'(N_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    ack_d   = '0;
    data_d  = data_q;
    last_d  = last_q;
`ifdef UART_ARB_WDT_EN
    wdt_d     = wdt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UART_ARB_WDT_EN
        wdt_d = '0;
`endif
        if (any_req) begin
          owner_d = winner;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.i_req[owner_q] && bus.i_mty) begin
          we_d    = 1'b1;
          data_d  = owner_byte;
          ack_d   = N_REQ'(1) << owner_q;
          last_d  = bus.i_last[owner_q];
          state_d = ST_GAP;
`ifdef UART_ARB_WDT_EN
          wdt_d   = '0;
        end else if (!bus.i_req[owner_q]) begin
          if (wdt_q == WDT_MAX) begin
            busy_d    = 1'b0;
            ptr_d     = ptr_after;
            timeout_d = 1'b1;
            wdt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            wdt_d = wdt_q + WDT_W'(1);
          end
`endif
        end
      end
      ST_GAP: begin
        if (last_q) begin
          busy_d  = 1'b0;
          ptr_d   = ptr_after;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state and outputs; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef UART_ARB_WDT_EN
      wdt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef UART_ARB_WDT_EN
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.o_we    = we_q;
  assign bus.o_ack   = ack_q;
  assign bus.o_data  = data_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_owner = owner_q;
`ifdef UART_ARB_WDT_EN
  assign bus.o_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, packets, round-robin, stall, reset mid-packet, lock.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .WIDTH_DATA(W)) bus ();

`ifdef UART_ARB_WDT_EN
  uart_tx_arbiter #(.N_REQ(N), .WIDTH_DATA(W), .TIMEOUT(16)) dut (
`else
  uart_tx_arbiter #(.N_REQ(N), .WIDTH_DATA(W)) dut (
`endif
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int k, input logic [7:0] d, input logic last);
    bus.i_data[k*W +: W] = d;
    bus.i_last[k]        = last;
    bus.i_req[k]         = 1'b1;
  endtask

  task automatic drop(input int k);
    bus.i_req[k]  = 1'b0;
    bus.i_last[k] = 1'b0;
  endtask

  // Advance until o_we is seen or the cycle budget runs out; callers check o_we afterwards.
  task automatic wait_we(input int limit, output int cyc);
    step();
    cyc = 1;
    while (bus.o_we !== 1'b1 && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int bad;
    nrst       = 1'b0;
    bus.i_req  = '0;
    bus.i_last = '0;
    bus.i_data = '0;
    bus.i_mty  = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.o_ack, bus.o_we, bus.o_data, bus.o_busy, bus.o_owner} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b we=%b data=%h busy=%b owner=%0d, expected all 0",
               bus.o_ack, bus.o_we, bus.o_data, bus.o_busy, bus.o_owner);
    end
    nrst = 1'b1;
    bad  = 0;
    repeat (50) begin
      step();
      if (bus.o_we !== 1'b0 || bus.o_ack !== '0 || bus.o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] pkt [3] = '{8'h11, 8'h22, 8'h33};
    int cyc;
    set_byte(1, pkt[0], 1'b0);
    step();
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_owner !== 2'd1 || bus.o_we !== 1'b0) begin
      errors++;
      $display("FAIL arb_cycle: busy=%b owner=%0d we=%b, expected busy=1 owner=1 we=0",
               bus.o_busy, bus.o_owner, bus.o_we);
    end
    for (int b = 0; b < 3; b++) begin
      if (b > 0) set_byte(1, pkt[b], b == 2);
      wait_we(20, cyc);
      checks++;
      if (bus.o_we !== 1'b1 || bus.o_data !== pkt[b] || bus.o_ack !== 4'b0010 ||
          bus.o_owner !== 2'd1 || cyc != (b == 0 ? 1 : 2)) begin
        errors++;
        $display("FAIL pkt1_byte%0d: we=%b data=%h ack=%b owner=%0d cyc=%0d, expected we=1 data=%h ack=0010 owner=1 cyc=%0d",
                 b, bus.o_we, bus.o_data, bus.o_ack, bus.o_owner, cyc, pkt[b], (b == 0 ? 1 : 2));
      end
    end
    drop(1);
    step();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_we !== 1'b0 || bus.o_ack !== '0) begin
      errors++;
      $display("FAIL pkt1_release: busy=%b we=%b ack=%b, expected 0 0 0000",
               bus.o_busy, bus.o_we, bus.o_ack);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    int exp;
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    step();
    for (int k = 0; k < N; k++) set_byte(k, 8'(8'hA0 + k), 1'b1);
    for (int g = 0; g < 2 * N; g++) begin
      exp = g % N;
      wait_we(20, cyc);
      checks++;
      if (bus.o_we !== 1'b1 || bus.o_ack !== 4'(1 << exp) || bus.o_data !== 8'(8'hA0 + exp) ||
          bus.o_owner !== 2'(exp)) begin
        errors++;
        $display("FAIL rr_grant%0d: we=%b ack=%b data=%h owner=%0d, expected we=1 owner=%0d data=%h",
                 g, bus.o_we, bus.o_ack, bus.o_data, bus.o_owner, exp, 8'(8'hA0 + exp));
      end
    end
    for (int k = 0; k < N; k++) drop(k);
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pkt [3] = '{8'h2A, 8'h2B, 8'h2C};
    int cyc;
    set_byte(2, pkt[0], 1'b0);
    step();
    set_byte(0, 8'h0F, 1'b1);
    for (int b = 0; b < 3; b++) begin
      wait_we(20, cyc);
      checks++;
      if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0100 || bus.o_data !== pkt[b]) begin
        errors++;
        $display("FAIL lock_byte%0d: we=%b ack=%b data=%h, expected we=1 ack=0100 data=%h",
                 b, bus.o_we, bus.o_ack, bus.o_data, pkt[b]);
      end
      if (b < 2) set_byte(2, pkt[b+1], b == 1);
      else drop(2);
    end
    wait_we(20, cyc);
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0001 || bus.o_data !== 8'h0F) begin
      errors++;
      $display("FAIL waiter_grant: we=%b ack=%b data=%h, expected we=1 ack=0001 data=0f",
               bus.o_we, bus.o_ack, bus.o_data);
    end
    drop(0);
    step();
  endtask

  task automatic test_mty_stall();
    int bad;
    bus.i_mty = 1'b0;
    set_byte(3, 8'h5A, 1'b1);
    bad = 0;
    repeat (100) begin
      step();
      if (bus.o_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || bus.o_busy !== 1'b1 || bus.o_owner !== 2'd3) begin
      errors++;
      $display("FAIL stall_hold: we_cycles=%0d busy=%b owner=%0d, expected 0 1 3",
               bad, bus.o_busy, bus.o_owner);
    end
    bus.i_mty = 1'b1;
    step();
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_data !== 8'h5A || bus.o_ack !== 4'b1000) begin
      errors++;
      $display("FAIL stall_release: we=%b data=%h ack=%b, expected we=1 data=5a ack=1000",
               bus.o_we, bus.o_data, bus.o_ack);
    end
    drop(3);
    step();
    checks++;
    if (bus.o_we !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_single_pulse: we=%b busy=%b, expected 0 0", bus.o_we, bus.o_busy);
    end
  endtask

  task automatic test_reset_mid_packet();
    int cyc;
    int bad;
    set_byte(1, 8'h51, 1'b1);
    wait_we(20, cyc);
    drop(1);
    step();
    set_byte(3, 8'h61, 1'b0);
    wait_we(20, cyc);
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b1000 || bus.o_data !== 8'h61) begin
      errors++;
      $display("FAIL rst_pkt_byte0: we=%b ack=%b data=%h, expected we=1 ack=1000 data=61",
               bus.o_we, bus.o_ack, bus.o_data);
    end
    set_byte(3, 8'h62, 1'b0);
    step();
    #5 nrst = 1'b0;
    #1;
    checks++;
    if ({bus.o_ack, bus.o_we, bus.o_data, bus.o_busy, bus.o_owner} !== '0) begin
      errors++;
      $display("FAIL async_reset: ack=%b we=%b data=%h busy=%b owner=%0d, expected all 0",
               bus.o_ack, bus.o_we, bus.o_data, bus.o_busy, bus.o_owner);
    end
    drop(3);
    set_byte(0, 8'h70, 1'b1);
    set_byte(2, 8'h72, 1'b1);
    bad = 0;
    repeat (3) begin
      step();
      if (bus.o_we !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_quiet: %0d active cycles, expected 0", bad);
    end
    nrst = 1'b1;
    wait_we(20, cyc);
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0001 || bus.o_data !== 8'h70) begin
      errors++;
      $display("FAIL post_reset_grant: we=%b ack=%b data=%h, expected we=1 ack=0001 data=70",
               bus.o_we, bus.o_ack, bus.o_data);
    end
    drop(0);
    wait_we(20, cyc);
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0100 || bus.o_data !== 8'h72) begin
      errors++;
      $display("FAIL post_reset_second: we=%b ack=%b data=%h, expected we=1 ack=0100 data=72",
               bus.o_we, bus.o_ack, bus.o_data);
    end
    drop(2);
    step();
  endtask

  task automatic test_owner_drop();
    int cyc;
    set_byte(1, 8'h81, 1'b0);
    set_byte(2, 8'h92, 1'b1);
    wait_we(20, cyc);
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0010 || bus.o_data !== 8'h81) begin
      errors++;
      $display("FAIL drop_first: we=%b ack=%b data=%h, expected we=1 ack=0010 data=81",
               bus.o_we, bus.o_ack, bus.o_data);
    end
    drop(1);
`ifdef UART_ARB_WDT_EN
    cyc = 0;
    while (bus.o_timeout !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (bus.o_timeout !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_we !== 1'b0 || cyc != 17) begin
      errors++;
      $display("FAIL wdt_timeout: timeout=%b busy=%b we=%b cyc=%0d, expected 1 0 0 17",
               bus.o_timeout, bus.o_busy, bus.o_we, cyc);
    end
`else
    begin
      int bad;
      bad = 0;
      repeat (40) begin
        step();
        if (bus.o_we !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_owner !== 2'd1) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL lock_held: %0d cycles lost the lock or wrote, expected 0", bad);
      end
      set_byte(1, 8'h83, 1'b1);
      wait_we(20, cyc);
      checks++;
      if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0010 || bus.o_data !== 8'h83) begin
        errors++;
        $display("FAIL lock_resume: we=%b ack=%b data=%h, expected we=1 ack=0010 data=83",
                 bus.o_we, bus.o_ack, bus.o_data);
      end
      drop(1);
    end
`endif
    wait_we(20, cyc);
    checks++;
    if (bus.o_we !== 1'b1 || bus.o_ack !== 4'b0100 || bus.o_data !== 8'h92) begin
      errors++;
      $display("FAIL next_after_drop: we=%b ack=%b data=%h, expected we=1 ack=0100 data=92",
               bus.o_we, bus.o_ack, bus.o_data);
    end
    drop(2);
    step();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_to_back();
    test_mty_stall();
    test_reset_mid_packet();
    test_owner_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
